mips_hilo_muldiv_unit: RTL and testbench

//  Parametrised HI/LO multiply/divide unit for the Harvard MIPS core. Executes MULT, MULTU, DIV, DIVU

---
 rtl/mips_hilo_muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_mips_hilo_muldiv_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mips_hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: iterative shift-add multiply and restoring
// divide with signed magnitude fixup, optional single-cycle multiply.
module mips_hilo_muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter int FAST_MULT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIXUP
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_b;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_sgn;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [2*WIDTH-1:0] w_fast_prod;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_madd;
    logic [WIDTH:0]   w_dsh;
    logic [WIDTH:0]   w_dsub;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    // Operand magnitudes, one iteration step and the sign fixup values
    always_comb begin
        w_sgn       = ~op[0];
        w_mag_a     = (w_sgn && op_a[WIDTH-1]) ? -op_a : op_a;
        w_mag_b     = (w_sgn && op_b[WIDTH-1]) ? -op_b : op_b;
        w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
        w_addend    = r_acc_lo[0] ? r_b : '0;
        w_madd      = {1'b0, r_acc_hi} + {1'b0, w_addend};
        w_dsh       = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_dsub      = w_dsh - {1'b0, r_b};
        w_prod      = {r_acc_hi, r_acc_lo};
        w_prod_s    = r_neg_q ? -w_prod : w_prod;
        w_quo       = r_neg_q ? -r_acc_lo : r_acc_lo;
        w_rem       = r_neg_r ? -r_acc_hi : r_acc_hi;
    end

    // Control FSM, datapath iteration and HI/LO update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (clk_enable) begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            3'd4: r_hi <= op_a;
                            3'd5: r_lo <= op_a;
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                r_busy   <= 1'b1;
                                r_cnt    <= '0;
                                r_is_div <= op[1];
                                r_neg_q  <= w_sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                                r_neg_r  <= w_sgn & op_a[WIDTH-1];
                                if (op[1]) begin
                                    r_acc_hi <= '0;
                                    r_acc_lo <= w_mag_a;
                                    r_b      <= w_mag_b;
                                    r_state  <= S_RUN;
                                end else if (FAST_MULT != 0) begin
                                    r_acc_hi <= w_fast_prod[2*WIDTH-1:WIDTH];
                                    r_acc_lo <= w_fast_prod[WIDTH-1:0];
                                    r_b      <= w_mag_a;
                                    r_state  <= S_FIXUP;
                                end else begin
                                    r_acc_hi <= '0;
                                    r_acc_lo <= w_mag_b;
                                    r_b      <= w_mag_a;
                                    r_state  <= S_RUN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        if (!w_dsub[WIDTH]) begin
                            r_acc_hi <= w_dsub[WIDTH-1:0];
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc_hi <= w_dsh[WIDTH-1:0];
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_acc_hi <= w_madd[WIDTH:1];
                        r_acc_lo <= {w_madd[0], r_acc_lo[WIDTH-1:1]};
                    end
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_FIXUP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIXUP: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (r_is_div) begin
                        if (r_b == '0) begin
                            r_dbz <= 1'b1;
                        end else begin
                            r_lo <= w_quo;
                            r_hi <= w_rem;
                        end
                    end else begin
                        r_hi <= w_prod_s[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_s[WIDTH-1:0];
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_mips_hilo_muldiv_unit.sv
// Directed bench for the HI/LO mul/div unit: iterative and fast
// multiply instances driven with hand-computed vectors.
module tb_mips_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        start;
    logic        f_start;
    logic [2:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;
    logic        f_busy, f_done, f_dbz;
    logic [31:0] f_hi, f_lo;

    int checks   = 0;
    int failures = 0;
    int lat;

    always #5 clk = ~clk;

    mips_hilo_muldiv_unit #(.WIDTH(32), .FAST_MULT(0)) u_slow (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .div_by_zero(dbz),
        .hi(hi), .lo(lo)
    );

    mips_hilo_muldiv_unit #(.WIDTH(32), .FAST_MULT(1)) u_fast (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .start(f_start), .op(op), .op_a(op_a), .op_b(op_b),
        .busy(f_busy), .done(f_done), .div_by_zero(f_dbz),
        .hi(f_hi), .lo(f_lo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op on the slow unit and count cycles from E0 to done
    task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int n);
        op = o; op_a = a; op_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        reset = 1'b1; clk_enable = 1'b1; start = 1'b0; f_start = 1'b0;
        op = 3'd0; op_a = '0; op_b = '0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_hilo", {hi, lo}, 64'h0);
        chk("reset_flags", {busy, done, dbz}, 3'b000);
        chk("reset_fast", {f_hi, f_lo, f_busy, f_done}, 66'h0);

        // 1. MULTU 7*6
        op = 3'd1; op_a = 32'd7; op_b = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        chk("multu_busy", busy, 1'b1);
        lat = 0;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
        chk("multu_lat", lat, 33);
        chk("multu_res", {hi, lo}, {32'd0, 32'd42});
        chk("multu_busy_end", busy, 1'b0);
        tick();
        chk("done_pulse", done, 1'b0);

        // 2. MULT -3*5, iterative then fast
        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, lat);
        chk("mult_lat", lat, 33);
        chk("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        op = 3'd0; op_a = 32'hFFFF_FFFD; op_b = 32'd5; f_start = 1'b1;
        tick();
        f_start = 1'b0;
        chk("fast_e0", {f_busy, f_done}, 2'b10);
        tick();
        chk("fast_done", {f_busy, f_done, f_dbz}, 3'b010);
        chk("fast_res", {f_hi, f_lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        // 3. DIV -7/2, DIVU 100/7, MINNEG/-1, back-to-back MTHI
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat);
        chk("div_lat", lat, 33);
        chk("div_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_nodbz", dbz, 1'b0);
        run_op(3'd3, 32'd100, 32'd7, lat);
        chk("divu_res", {hi, lo}, {32'd2, 32'd14});
        op = 3'd4; op_a = 32'h0000_ABCD; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_mthi", {hi, lo}, {32'h0000_ABCD, 32'd14});
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("div_ovf", {hi, lo, dbz}, {32'd0, 32'h8000_0000, 1'b0});

        // 4. MTHI/MTLO then divide by zero
        op = 3'd4; op_a = 32'h1234; start = 1'b1;
        tick();
        op = 3'd5; op_a = 32'h5678;
        tick();
        start = 1'b0;
        chk("mt_flags", {busy, done}, 2'b00);
        chk("mt_vals", {hi, lo}, {32'h1234, 32'h5678});
        op = 3'd6; op_a = 32'h9999; start = 1'b1;
        tick();
        start = 1'b0;
        chk("noop_ign", {busy, hi, lo}, {1'b0, 32'h1234, 32'h5678});
        run_op(3'd3, 32'd100, 32'd0, lat);
        chk("dbz_lat", lat, 33);
        chk("dbz_flag", {done, dbz}, 2'b11);
        chk("dbz_hold", {hi, lo}, {32'h1234, 32'h5678});

        // 5. MULTU max*max with 5 stalled cycles and a busy start
        op = 3'd1; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        repeat (3) begin tick(); lat++; end
        op = 3'd1; op_a = 32'd2; op_b = 32'd2; start = 1'b1;
        tick(); lat++;
        start = 1'b0;
        repeat (6) begin tick(); lat++; end
        clk_enable = 1'b0;
        repeat (5) begin tick(); lat++; end
        chk("stall_busy", {busy, done}, 2'b10);
        clk_enable = 1'b1;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
        chk("stall_lat", lat, 38);
        chk("stall_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        clk_enable = 1'b0;
        tick();
        chk("done_held", done, 1'b1);
        clk_enable = 1'b1;
        tick();
        chk("done_clear", {done, busy}, 2'b00);

        // 6. reset mid-DIV, then MULTU 3*3
        op = 3'd2; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid", {busy, done, dbz}, 3'b000);
        chk("rst_hilo", {hi, lo}, 64'h0);
        lat = 0;
        repeat (40) begin
            tick();
            if (done) lat++;
        end
        chk("rst_nodone", lat, 0);
        run_op(3'd1, 32'd3, 32'd3, lat);
        chk("post_rst", {hi, lo}, {32'd0, 32'd9});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
